sar_search: RTL and testbench

- Sequential controller that sits on the driving side of the existing N-bit magnitude comparator (`comp`).
- It drives the comparator's `in0` with a trial value and consumes the comparator's `gt`/`eq`/`lt` verdict against an external target on `in1`.
- It runs a successive-approximation (binary) search, MSB first, to recover the target value.
- Typical use: an ADC-style SAR loop, or threshold discovery against a comparator whose `in1` the block cannot read.

---
 rtl/sar_search_pkg.sv | 17 +
 rtl/sar_search.sv | 129 ++++++++++++
 tb/tb_sar_search.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// sar_search_pkg
// Shared definitions for the successive-approximation search controller.
// Holds the default operand width and the FSM state encoding so that the
// controller and anything observing it agree on the same values.
package sar_search_pkg;

  // Default width of the trial value, result and comparator operands
  localparam int N_DEFAULT = 8;

  // Controller states; encodings are fixed so external observers can decode them
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search.sv
// sar_search
// Successive-approximation (binary, MSB-first) search controller that drives
// the in0 side of an external magnitude comparator and recovers the value on
// the comparator's in1 from its gt/eq/lt verdicts, one bit per clock.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - begin a search (only looked at in IDLE)
//   gt     - comparator verdict: guess > target
//   eq     - comparator verdict: guess == target
//   lt     - comparator verdict: guess < target
//   guess  - trial value, wired to comparator in0
//   busy   - high while searching
//   done   - one-cycle pulse when result becomes valid
//   result - recovered target, held until the next start
//   exact  - an eq verdict ended the search (valid with done, held with result)
//   err    - sticky flag: verdict was not one-hot during the search
module sar_search
  import sar_search_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         gt,
  input  logic         eq,
  input  logic         lt,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         exact,
  output logic         err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  kept;
  logic [N-1:0]  nextBit;
  logic          verdictBad;

  // Work out the trial value with the current bit decided. A gt verdict
  // means the bit under test overshoots and must be dropped; lt (or no
  // verdict at all) keeps it. nextBit is the next lower bit to try.
  always_comb begin
    kept    = guess;
    nextBit = '0;
    if (gt) begin
      kept[idx] = 1'b0;
    end
    if (idx != '0) begin
      nextBit[idx - 1'b1] = 1'b1;
    end
  end

  // A healthy comparator asserts exactly one of its three verdicts
  assign verdictBad = !$onehot({gt, eq, lt});

  // Main controller: every output is registered. The eq check comes first so
  // it wins over gt/lt when the comparator misbehaves, and gt is applied
  // through kept so it in turn wins over lt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= IW'(N - 1);
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      exact  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            guess <= {1'b1, {(N-1){1'b0}}};
            idx   <= IW'(N - 1);
            err   <= 1'b0;
            exact <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end

        SEARCH: begin
          if (verdictBad) begin
            err <= 1'b1;
          end
          if (eq) begin
            result <= guess;
            exact  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (idx == '0) begin
            result <= kept;
            exact  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            guess <= kept | nextBit;
            idx   <= idx - 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          guess <= '0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          guess <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search
// Directed bench for sar_search with N=8. A behavioural comparator closes the
// loop between guess and a bench-held target; it can be overridden to inject
// illegal verdicts.
module tb_sar_search;
  import sar_search_pkg::*;

  localparam int N = N_DEFAULT;

  logic         clk;
  logic         rst;
  logic         start;
  logic         gt;
  logic         eq;
  logic         lt;
  logic [N-1:0] guess;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         exact;
  logic         err;

  logic [N-1:0] target;
  logic         override;
  logic [2:0]   forcedVerdict;

  int compared;
  int mismatched;

  logic [7:0] seqZero [8];
  logic [7:0] seqFull [8];
  logic [7:0] seq5a   [7];

  sar_search #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .exact  (exact),
    .err    (err)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural comparator; forcedVerdict is {gt, eq, lt} when overriding
  always_comb begin
    if (override) begin
      {gt, eq, lt} = forcedVerdict;
    end else begin
      gt = (guess > target);
      eq = (guess == target);
      lt = (guess < target);
    end
  end

  // Hard stop in case the bench itself stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge with a given target on the comparator
  task automatic applyStimulus(input logic [N-1:0] tgt);
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Wait up to budget edges for done; an expired budget shows up as a failure
  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    start         = 1'b0;
    target        = '0;
    override      = 1'b0;
    forcedVerdict = 3'b000;
    seqZero = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    seqFull = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    seq5a   = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};

    // Reset values
    tick();
    tick();
    checkOutput("rst_state",  32'(dut.state), 32'(IDLE));
    checkOutput("rst_guess",  32'(guess),  32'h0);
    checkOutput("rst_busy",   32'(busy),   32'h0);
    checkOutput("rst_done",   32'(done),   32'h0);
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_exact",  32'(exact),  32'h0);
    checkOutput("rst_err",    32'(err),    32'h0);
    rst = 1'b0;
    tick();
    checkOutput("idle_hold_busy", 32'(busy), 32'h0);

    // Target 0x80: eq on the very first trial
    applyStimulus(8'h80);
    checkOutput("t80_busy",  32'(busy),  32'h1);
    checkOutput("t80_guess", 32'(guess), 32'h80);
    tick();
    checkOutput("t80_done",   32'(done),   32'h1);
    checkOutput("t80_busy2",  32'(busy),   32'h0);
    checkOutput("t80_result", 32'(result), 32'h80);
    checkOutput("t80_exact",  32'(exact),  32'h1);
    checkOutput("t80_err",    32'(err),    32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t80_done_off",   32'(done),  32'h0);
    checkOutput("t80_guess_clr",  32'(guess), 32'h0);
    checkOutput("t80_start_ign",  32'(busy),  32'h0);
    tick();
    checkOutput("t80_still_idle", 32'(busy),  32'h0);

    // Target 0x00: every trial overshoots, result deduced without eq
    applyStimulus(8'h00);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("t00_guess%0d", j), 32'(guess), 32'(seqZero[j]));
      checkOutput($sformatf("t00_busy%0d", j), 32'(busy), 32'h1);
      tick();
    end
    checkOutput("t00_done",   32'(done),   32'h1);
    checkOutput("t00_result", 32'(result), 32'h00);
    checkOutput("t00_exact",  32'(exact),  32'h0);
    tick();

    // Target 0xFF: every trial undershoots until the final eq
    applyStimulus(8'hFF);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("tff_guess%0d", j), 32'(guess), 32'(seqFull[j]));
      tick();
    end
    checkOutput("tff_done",   32'(done),   32'h1);
    checkOutput("tff_result", 32'(result), 32'hFF);
    checkOutput("tff_exact",  32'(exact),  32'h1);
    tick();

    // Target 0x5A with start re-pulsed mid-search; eq arrives at the bit-1 trial
    applyStimulus(8'h5A);
    for (int j = 0; j < 7; j++) begin
      checkOutput($sformatf("t5a_guess%0d", j), 32'(guess), 32'(seq5a[j]));
      start = (j == 2);
      tick();
    end
    start = 1'b0;
    checkOutput("t5a_done",   32'(done),   32'h1);
    checkOutput("t5a_result", 32'(result), 32'h5A);
    checkOutput("t5a_exact",  32'(exact),  32'h1);
    tick();
    checkOutput("t5a_no_restart", 32'(busy), 32'h0);

    // Target 0x37 back to back
    applyStimulus(8'h37);
    waitDone(12, "t37_done");
    checkOutput("t37_result", 32'(result), 32'h37);
    checkOutput("t37_exact",  32'(exact),  32'h1);
    tick();

    // Reset during the 4th search cycle: abort without done
    applyStimulus(8'h33);
    tick();
    tick();
    tick();
    checkOutput("t33_guess4", 32'(guess), 32'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t33_busy",   32'(busy),   32'h0);
    checkOutput("t33_guess",  32'(guess),  32'h0);
    checkOutput("t33_result", 32'(result), 32'h0);
    checkOutput("t33_done",   32'(done),   32'h0);
    tick();
    checkOutput("t33_done2",  32'(done),   32'h0);
    checkOutput("t33_idle",   32'(busy),   32'h0);

    // Illegal verdict gt=lt=1 on the first trial of target 0x40
    applyStimulus(8'h40);
    override      = 1'b1;
    forcedVerdict = 3'b101;
    tick();
    override      = 1'b0;
    checkOutput("err_set",   32'(err),   32'h1);
    checkOutput("err_guess", 32'(guess), 32'h40);
    tick();
    checkOutput("err_done",   32'(done),   32'h1);
    checkOutput("err_sticky", 32'(err),    32'h1);
    checkOutput("err_result", 32'(result), 32'h40);
    tick();
    tick();
    checkOutput("err_hold_idle", 32'(err), 32'h1);
    applyStimulus(8'h80);
    checkOutput("err_cleared", 32'(err), 32'h0);
    waitDone(12, "err_next_done");
    checkOutput("err_next_err", 32'(err), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
